// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-step shift-add multiply / restoring divide owning HI/LO.
// Fixed 33-cycle latency from start edge to commit; MTHI/MTLO writes only when idle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wd_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, acc_q, x_q, hi_q, lo_q;
  logic [WIDTH-1:0] acc_d, x_d, hi_d, lo_d, rs_mag, rt_mag, sub;
  logic             neg_q, rs_neg_q, dz_q, busy_q, done_q;
  logic             sgn, ge;
  logic [WIDTH:0]   sum, sh;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sgn    = ~op_i[0];
    rs_mag = (sgn & rs_i[WIDTH-1]) ? -rs_i : rs_i;
    rt_mag = (sgn & rt_i[WIDTH-1]) ? -rt_i : rt_i;
    sum    = {1'b0, acc_q} + (x_q[0] ? {1'b0, a_q} : '0);
    sh     = {acc_q, x_q[WIDTH-1]};
    ge     = sh >= {1'b0, a_q};
    sub    = sh[WIDTH-1:0] - a_q;
    acc_d  = op_q[1] ? (ge ? sub : sh[WIDTH-1:0]) : sum[WIDTH:1];
    x_d    = op_q[1] ? {x_q[WIDTH-2:0], ge} : {sum[0], x_q[WIDTH-1:1]};
    prod   = neg_q ? -{acc_q, x_q} : {acc_q, x_q};
    // A zero divisor leaves rem=|rs|, so re-signing it restores the original rs in HI
    hi_d   = op_q[1] ? (rs_neg_q ? -acc_q : acc_q) : prod[2*WIDTH-1:WIDTH];
    lo_d   = op_q[1] ? (dz_q ? '1 : (neg_q ? -x_q : x_q)) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= CALC;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            op_q     <= op_i;
            acc_q    <= '0;
            a_q      <= op_i[1] ? rt_mag : rs_mag;
            x_q      <= op_i[1] ? rs_mag : rt_mag;
            neg_q    <= sgn & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
            rs_neg_q <= sgn & rs_i[WIDTH-1];
            dz_q     <= rt_i == '0;
          end else begin
            if (hi_we_i) hi_q <= wd_i;
            if (lo_we_i) lo_q <= wd_i;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          x_q   <= x_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors against hand-computed HI/LO results and timing.
module tb_mult_div_unit;
  logic        clk, rst_n, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] rs, rt, wd, hi, lo;
  int          n_tests = 0, n_fail = 0;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .rs_i(rs), .rt_i(rt),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wd_i(wd),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int k, output bit changed);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    k = 0;
    changed = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (!done && (hi !== h0 || lo !== l0)) changed = 1'b1;
    end
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int k;
    bit ch;
    launch(o, a, b);
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(k, ch);
    check({tag, " latency"}, k, 33);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " hold"}, 32'(ch), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done width"}, 32'(done), 32'd0);
  endtask
  initial begin
    int k, pulses;
    bit ch;
    rst_n = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    hi_we = 1'b1; wd = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h1234);
    lo_we = 1'b1; wd = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'h5678);
    launch(2'b01, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", pulses, 0);
    check("abort lo kept", lo, 32'h0);
    run("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult -7x6", 2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    run("divu 100/0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("mult min x -1", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    launch(2'b11, 32'd9, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; rs = 32'd2; rt = 32'd2; lo_we = 1'b1; wd = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    wait_done(k, ch);
    check("ignored start latency", k + 5, 33);
    check("divu 9/4 lo", lo, 32'd2);
    check("divu 9/4 hi", hi, 32'd1);
    check("calc lo_we ignored", 32'(ch), 32'd0);
    lo_we = 1'b1; wd = 32'hBEEF;
    launch(2'b01, 32'd2, 32'd2);
    lo_we = 1'b0;
    wait_done(k, ch);
    check("b2b latency", k, 33);
    check("b2b lo", lo, 32'd4);
    check("b2b hi", hi, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit holding the architectural HI/LO registers of the MIPS core. It sits directly downstream of the register file: it consumes the two read-port values (rs on RD1, rt on RD2) for MULT/MULTU/DIV/DIVU. It performs a 32-step shift-add multiply or restoring divide, and exposes HI/LO for MFHI/MFLO writeback. A `busy` output lets the control path stall dependent instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation; sampled only when `busy`=0.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs`  in  WIDTH  first operand (multiplicand / dividend), from register file RD1.
- `rt`  in  WIDTH  second operand (multiplier / divisor), from register file RD2.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wd`  in  WIDTH  MTHI/MTLO write data.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle pulse when HI/LO receive a result.
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.

## Operation
- The FSM has three states:
  - IDLE: `busy`=0.
  - CALC: `busy`=1, 5-bit counter runs 0..WIDTH-1.
  - FIX: `busy`=1, sign correction and commit.
- IDLE + `start` → CALC. On the same edge, latch operand magnitudes and the op, and clear the accumulator and counter.
  - For signed ops (MULT, DIV), the magnitude is the two's-complement absolute value. 0x80000000 maps to unsigned 0x80000000.
- CALC performs one step per cycle:
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper accumulator with carry, then shift the 64-bit {acc, multiplier} right by 1.
  - Divide (restoring): shift {rem, quotient} left by 1. Trial-subtract the divisor from rem; if there is no borrow, keep the difference and set the quotient LSB.
- When the counter reaches WIDTH-1, CALC → FIX.
- FIX commits the result and returns to IDLE:
  - MULT: negate the 64-bit product if sign(rs)≠sign(rt). HI = product[63:32], LO = product[31:0].
  - DIV: negate the quotient if sign(rs)≠sign(rt), and give the remainder the sign of rs. LO = quotient, HI = remainder.
  - Unsigned ops: no correction.
  - Assert `done` and go to IDLE.
- Divide by zero (rt=0, either DIV or DIVU) still runs the full sequence. Result is LO=0xFFFFFFFF, HI=rs (original, uncorrected).
- -2^31 / -1 (DIV) gives LO=0x80000000, HI=0.
- `hi`/`lo` are the committed registers only. They hold their previous values throughout CALC; internal accumulators are separate.
- MTHI/MTLO are accepted only in IDLE with `start`=0. `hi_we`/`lo_we` write `wd` on the edge, and both may fire together.
  - If `start` and a write enable are both high in IDLE, `start` wins and the write is dropped.
  - Write enables during CALC/FIX are ignored.
- `start` while `busy`=1 is ignored; there is no queueing.
- Operands are sampled only at the start edge. Later changes on `rs`/`rt` have no effect.

## Timing
- Reset (`rst_n`=0, asynchronous) forces `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, and counter 0.
  - Reset mid-operation aborts it with no commit.
  - Release is synchronous to `clk` with respect to the next start.
- Start sampled at edge E0 gives this sequence:
  - `busy`=1 from E0 to E33.
  - CALC iterations run on edges E1..E32.
  - FIX commits on E33, where `hi`/`lo` update and `done`=1 for exactly the cycle following E33.
  - `busy` returns to 0 at E33.
- Latency from start edge to result-visible edge is 33 cycles, identical for all ops and operand values.
- A new `start` is accepted on E33+1 at the earliest, i.e. the cycle where `done`=1. This gives back-to-back throughput of one op per 34 cycles.
- MTHI/MTLO results are visible the cycle after the write edge.
- `busy` and `done` are registered outputs with no combinational path from the inputs.

## Test plan
- Reset mid-op: start MULTU 3×5, assert `rst_n`=0 at cycle 10 → immediately `busy`=0, `hi`=`lo`=0, and `done` never pulses.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, `done` one cycle.
- MULT -7 (0xFFFFFFF9) × 6 → HI=0xFFFFFFFF, LO=0xFFFFFFD6; HI/LO unchanged during the 32 CALC cycles.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Pulse `start` (MULTU 2×2) at cycle 5 of a running DIVU 9/4 → it is ignored; result is LO=2, HI=1.
  - A new start on the `done` cycle is accepted and yields LO=4 thirty-three cycles later.
- Hold `hi_we`=1, `wd`=0x1234 in IDLE → HI=0x1234.
  - `lo_we` during CALC is ignored.
  - `start` with `lo_we` together → LO gets the op result, not `wd`.
